// File: rtl/seven_segment_counter_mux.sv
// rtl/seven_segment_counter_mux.sv - debounced up/down multi-digit counter on a scanned seven-segment display
// Buttons are synchronised and debounced; the value is shown one digit at a time.
module seven_segment_counter_mux #(
  parameter int DIGITS          = 4,
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BCD             = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  leftButton,
  input  logic                  rightButton,
  output logic [6:0]            segmentBits,
  output logic [DIGITS-1:0]     grounds,
  output logic [4*DIGITS-1:0]   value
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [3:0]    NIB_MAX  = (BCD != 0) ? 4'd9 : 4'd15;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Bit 0 is the right (increment) button, bit 1 the left (decrement) button.
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          stable_q, stable_d;
  logic [1:0]          stable_prev_q, stable_prev_d;
  logic [CW-1:0]       deb_q [2];
  logic [CW-1:0]       deb_d [2];
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [RW-1:0]       refresh_q, refresh_d;
  logic [IW-1:0]       scan_idx_q, scan_idx_d;

  logic [1:0] press;
  logic       carry;
  logic [3:0] nib;
  logic [3:0] digit;

  assign press = stable_q & ~stable_prev_q;

  always_comb begin
    sync1_d       = {leftButton, rightButton};
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    for (int b = 0; b < 2; b++) begin
      deb_d[b] = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (deb_q[b] == DEB_LAST) stable_d[b] = ~stable_q[b];
        else                      deb_d[b]    = deb_q[b] + CW'(1);
      end
    end
  end

  // Ripple the carry/borrow nibble by nibble so BCD and hex share one path.
  always_comb begin
    value_d = value_q;
    carry   = 1'b1;
    nib     = '0;
    if (press[0] ^ press[1]) begin
      for (int k = 0; k < DIGITS; k++) begin
        nib = value_q[4*k +: 4];
        if (carry) begin
          if (press[0]) begin
            if (nib == NIB_MAX) nib = 4'd0;
            else begin
              nib   = nib + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (nib == 4'd0) nib = NIB_MAX;
            else begin
              nib   = nib - 4'd1;
              carry = 1'b0;
            end
          end
        end
        value_d[4*k +: 4] = nib;
      end
    end
  end

  always_comb begin
    refresh_d  = refresh_q + RW'(1);
    scan_idx_d = scan_idx_q;
    if (refresh_q == REF_LAST) begin
      refresh_d  = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      deb_q[0]      <= '0;
      deb_q[1]      <= '0;
      value_q       <= '0;
      refresh_q     <= '0;
      scan_idx_q    <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      deb_q[0]      <= deb_d[0];
      deb_q[1]      <= deb_d[1];
      value_q       <= value_d;
      refresh_q     <= refresh_d;
      scan_idx_q    <= scan_idx_d;
    end
  end

  always_comb begin
    grounds = '1;
    digit   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == scan_idx_q) begin
        grounds[k] = 1'b0;
        digit      = value_q[4*k +: 4];
      end
    end
  end

  always_comb begin
    case (digit)
      4'h0: segmentBits = 7'b1111110;
      4'h1: segmentBits = 7'b0110000;
      4'h2: segmentBits = 7'b1101101;
      4'h3: segmentBits = 7'b1111001;
      4'h4: segmentBits = 7'b0110011;
      4'h5: segmentBits = 7'b1011011;
      4'h6: segmentBits = 7'b1011111;
      4'h7: segmentBits = 7'b1110000;
      4'h8: segmentBits = 7'b1111111;
      4'h9: segmentBits = 7'b1111011;
      4'hA: segmentBits = 7'b1110111;
      4'hB: segmentBits = 7'b0011111;
      4'hC: segmentBits = 7'b1001110;
      4'hD: segmentBits = 7'b0111101;
      4'hE: segmentBits = 7'b1001111;
      default: segmentBits = 7'b1000111;
    endcase
  end

  assign value = value_q;

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// tb/tb_seven_segment_counter_mux.sv - self-checking bench for seven_segment_counter_mux
// Hex and BCD instances share stimulus and are checked every cycle against an arithmetic model.
module tb_seven_segment_counter_mux;
  localparam int D   = 2;
  localparam int R   = 4;
  localparam int DEB = 3;

  logic clk, rst, lb, rb;
  logic [6:0]   seg_h, seg_b;
  logic [D-1:0] gnd_h, gnd_b;
  logic [4*D-1:0] val_h, val_b;

  int total = 0;
  int bad   = 0;

  seven_segment_counter_mux #(.DIGITS(D), .REFRESH_DIV(R), .DEBOUNCE_CYCLES(DEB), .BCD(0)) u_hex (
    .clk(clk), .rst(rst), .leftButton(lb), .rightButton(rb),
    .segmentBits(seg_h), .grounds(gnd_h), .value(val_h));

  seven_segment_counter_mux #(.DIGITS(D), .REFRESH_DIV(R), .DEBOUNCE_CYCLES(DEB), .BCD(1)) u_bcd (
    .clk(clk), .rst(rst), .leftButton(lb), .rightButton(rb),
    .segmentBits(seg_b), .grounds(gnd_b), .value(val_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: counts as plain integers, debounce as run lengths of delayed raw levels.
  int mh, mb, cyc;
  int h1 [2];
  int h2 [2];
  int st [2];
  int run [2];
  int pend [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;  3: return 7'b1111001;
      4: return 7'b0110011;  5: return 7'b1011011;  6: return 7'b1011111;  7: return 7'b1110000;
      8: return 7'b1111111;  9: return 7'b1111011; 10: return 7'b1110111; 11: return 7'b0011111;
      12: return 7'b1001110; 13: return 7'b0111101; 14: return 7'b1001111; default: return 7'b1000111;
    endcase
  endfunction

  function automatic int to_bcd(input int n);
    int r = 0;
    for (int k = 0; k < D; k++) begin
      r = r + ((n % 10) << (4*k));
      n = n / 10;
    end
    return r;
  endfunction

  function automatic void model_step(input logic r, input logic l, input logic rr);
    int lvl [2];
    int raw [2];
    int hmod, bmod;
    hmod = 1 << (4*D);
    bmod = 1;
    for (int k = 0; k < D; k++) bmod = bmod * 10;
    raw[0] = int'(rr);
    raw[1] = int'(l);
    if (r) begin
      mh = 0; mb = 0; cyc = 0;
      for (int b = 0; b < 2; b++) begin
        h1[b] = 0; h2[b] = 0; st[b] = 0; run[b] = 0; pend[b] = 0;
      end
    end else begin
      cyc++;
      if (pend[0] != pend[1]) begin
        if (pend[0] != 0) begin
          mh = (mh + 1) % hmod;
          mb = (mb + 1) % bmod;
        end else begin
          mh = (mh + hmod - 1) % hmod;
          mb = (mb + bmod - 1) % bmod;
        end
      end
      for (int b = 0; b < 2; b++) begin
        pend[b] = 0;
        lvl[b]  = h2[b];
        h2[b]   = h1[b];
        h1[b]   = raw[b];
        if (lvl[b] != st[b]) begin
          run[b]++;
          if (run[b] == DEB) begin
            st[b]  = lvl[b];
            run[b] = 0;
            if (st[b] != 0) pend[b] = 1;
          end
        end else begin
          run[b] = 0;
        end
      end
    end
  endfunction

  task automatic tick();
    int idx;
    logic [D-1:0] g;
    @(posedge clk);
    model_step(rst, lb, rb);
    #1;
    idx = (cyc / R) % D;
    g = '1;
    g[idx] = 1'b0;
    check("hex_val", 32'(val_h), 32'(mh));
    check("bcd_val", 32'(val_b), 32'(to_bcd(mb)));
    check("hex_gnd", 32'(gnd_h), 32'(g));
    check("bcd_gnd", 32'(gnd_b), 32'(g));
    check("hex_seg", 32'(seg_h), 32'(glyph((mh >> (4*idx)) & 15)));
    check("bcd_seg", 32'(seg_b), 32'(glyph((to_bcd(mb) >> (4*idx)) & 15)));
  endtask

  task automatic press(input bit left);
    if (left) lb = 1'b1; else rb = 1'b1;
    repeat (8) tick();
    lb = 1'b0;
    rb = 1'b0;
    repeat (8) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lb = 1'b0; rb = 1'b0;
    tick();
    do_reset();
    check("rst_value", 32'(val_h), 32'h00);
    check("rst_gnd", 32'(gnd_h), 32'b10);
    check("rst_seg", 32'(seg_h), 32'b1111110);
    repeat (4) tick();
    check("scan_4", 32'(gnd_h), 32'b01);
    repeat (4) tick();
    check("scan_8", 32'(gnd_h), 32'b10);

    rb = 1'b1; tick(); tick(); rb = 1'b0;
    repeat (8) tick();
    check("bounce", 32'(val_h), 32'h00);

    rb = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 5)  check("lat_e5", 32'(val_h), 32'h00);
      if (i == 6)  check("lat_e6", 32'(val_h), 32'h01);
      if (i == 20) check("no_repeat", 32'(val_h), 32'h01);
    end
    rb = 1'b0;
    repeat (8) tick();
    press(1'b0);
    check("repress", 32'(val_h), 32'h02);

    do_reset();
    press(1'b1);
    check("hex_wrap_dn", 32'(val_h), 32'hFF);
    check("bcd_wrap_dn", 32'(val_b), 32'h99);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("seg_F", 32'(seg_h), 32'b1000111);
    end
    press(1'b0);
    check("hex_wrap_up", 32'(val_h), 32'h00);
    check("bcd_wrap_up", 32'(val_b), 32'h00);

    repeat (9) press(1'b0);
    check("bcd_09", 32'(val_b), 32'h09);
    press(1'b0);
    check("bcd_10", 32'(val_b), 32'h10);
    check("hex_0a", 32'(val_h), 32'h0A);
    press(1'b1);
    check("bcd_dn09", 32'(val_b), 32'h09);

    lb = 1'b1; rb = 1'b1;
    repeat (12) tick();
    check("both_same", 32'(val_b), 32'h09);
    lb = 1'b0; rb = 1'b0;
    repeat (8) tick();

    rb = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) lb = 1'b1;
      if (i == 6) check("stagger_up", 32'(val_b), 32'h10);
      if (i == 7) check("stagger_dn", 32'(val_b), 32'h09);
    end
    lb = 1'b0; rb = 1'b0;
    repeat (8) tick();

    do_reset();
    rb = 1'b1;
    tick(); tick();
    do_reset();
    check("mid_rst_val", 32'(val_h), 32'h00);
    check("mid_rst_gnd", 32'(gnd_h), 32'b10);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) check("mid_rst_e5", 32'(val_h), 32'h00);
      if (i == 6) check("mid_rst_e6", 32'(val_h), 32'h01);
    end
    rb = 1'b0;

    for (int n = 0; n < 400; n++) begin
      lb  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 59) == 0);
      repeat ($urandom_range(1, 8)) tick();
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seven_segment_counter_mux.md
Name: seven_segment_counter_mux

Overview:
Parametrised successor to the single-digit button-driven seven-segment driver. It holds a multi-digit up/down counter and steps it with debounced left/right push buttons (left = decrement, right = increment). The value is shown on a time-multiplexed common-cathode display, one digit enabled at a time through active-low grounds. Hex or BCD counting is selected per instance. The block sits between board buttons and display pins.

Parameters:
DIGITS, 4, number of display digits / nibbles in the counter (1..8)
REFRESH_DIV, 50000, clock cycles each digit stays enabled before the scan advances (>=2)
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised button level must differ from its stable state before it is accepted (>=1)
BCD, 0, 0 = each nibble counts 0..F; 1 = each nibble counts 0..9 with decimal carry/borrow

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
leftButton  input  1  asynchronous raw button, high = pressed; press = decrement
rightButton  input  1  asynchronous raw button, high = pressed; press = increment
segmentBits  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a, high = lit
grounds  output  DIGITS  digit enables, active-low, exactly one bit low at any time
value  output  4*DIGITS  current counter value, nibble k = digit k, digit 0 least significant

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-high, sampled on the rising edge of clk.
- While rst is high at a clk edge: value=0, scan index=0, refresh count=0, sync flops=0, debounce counters=0, stable button states=0 (released).
- Outputs after reset: grounds = all ones except bit 0 low (DIGITS=4: 4'b1110); segmentBits = 7'b1111110 (glyph 0).
- Reset takes priority over every other event, including mid-debounce and mid-scan.
- Synchroniser: each button passes through 2 flip-flops before any other logic.
- Debounce: a per-button counter increments on each cycle where the synchronised level differs from the stable state.
  - It clears to 0 on any cycle where the level equals the stable state.
  - When the count reaches DEBOUNCE_CYCLES, the stable state toggles and the counter clears.
- Press event: a one-cycle pulse on each 0->1 transition of the stable state. Releases produce no event. Holding a button produces no auto-repeat.
- Latency: if a raw button goes high and stays high, value changes on exactly the (DEBOUNCE_CYCLES+3)th rising clk edge after it is first sampled high.
- Value update on the cycle following a pulse:
  - inc only: value+1.
  - dec only: value-1.
  - inc and dec in the same cycle: no change.
- Hex mode (BCD=0): modulo 16^DIGITS. All-F +1 -> 0; 0 -1 -> all-F.
- BCD mode (BCD=1): per-nibble decimal carry/borrow. 9..9 +1 -> 0; 0 -1 -> 9..9. Nibbles are never outside 0..9.
- Scan: the refresh counter runs 0..REFRESH_DIV-1. On the terminal count it wraps to 0 and the scan index advances; index wraps DIGITS-1 -> 0.
- Display outputs: grounds[index]=0 with all other bits 1. segmentBits = decode(value nibble[index]). Both are combinational from registered index/value, so they change in the same cycle as the index or value.
- Decode table:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- No leading-zero blanking; all digits are always shown.

Test Plan:
(Use DIGITS=2, REFRESH_DIV=4, DEBOUNCE_CYCLES=3 unless stated.)
- Reset then idle -> value=8'h00, segmentBits=7'b1111110, grounds=2'b10; grounds=2'b01 after 4 edges, 2'b10 after 8, period 8 cycles.
- rightButton high 2 cycles then low (bounce) -> value stays 8'h00. rightButton held 20 cycles -> value=8'h01 exactly at edge 6 after first sample, then no further change. Release and re-press -> 8'h02.
- Hex wrap: from 8'h00 press left -> 8'hFF, both digits show 7'b1000111. Press right -> 8'h00.
- BCD=1: 8'h09 +1 -> 8'h10; 8'h99 +1 -> 8'h00; 8'h00 -1 -> 8'h99; 8'h10 -1 -> 8'h09.
- Both buttons rise on the same cycle and are held -> value unchanged. Stagger them by 1 cycle -> value +1 then -1, net unchanged, two distinct updates.
- Assert rst for 1 cycle while rightButton held, 2 cycles into debounce -> no update at the old deadline; value=8'h00 and grounds=2'b10 after reset. Button still held -> value=8'h01 exactly DEBOUNCE_CYCLES+3 edges after reset deasserts.
